// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Request/response bundle between a data-memory requester and dmem_responder.
//   req_valid/req_ready : request handshake, accepted when both are high at an edge
//   req_write           : 1 = store, 0 = load
//   req_addr/req_wdata  : byte address and store data
//   resp_valid          : one-cycle response strobe, no back-pressure
//   resp_rdata          : load data (0 for stores and errors)
//   resp_error          : request was out of range or misaligned
interface dmem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
// Multi-cycle data-memory responder: accepts one load/store at a time, holds it
// for WAIT_CYCLES wait states, then returns a single-cycle response.
// All state changes on the falling edge of clock; clear is synchronous, active-high.
//   clock     : system clock (falling-edge active)
//   clear     : synchronous reset, reinitialises memory and counters
//   bus       : request/response bundle (slave side)
//   busy      : a request is in flight (inverse of req_ready)
//   err_count : saturating count of error responses
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | ready for a request
// ST_WAIT | request latched, counting down wait states
// ST_RESP | response presented for exactly one cycle
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clock,
    input  logic               clear,
    dmem_responder_if.slave    bus,
    output logic               busy,
    output logic [7:0]         err_count
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rdata_q;
    logic        error_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic             eff_write;
    logic [31:0]      eff_addr;
    logic [31:0]      eff_wdata;
    logic [31:0]      offset;
    logic             req_err;
    logic [IDX_W-1:0] idx;

    assign accept = (state == ST_IDLE) && bus.req_valid;

    // With zero wait states the response is formed on the acceptance edge,
    // so the live request fields are used instead of the latched copies.
    assign eff_write = accept ? bus.req_write : lat_write;
    assign eff_addr  = accept ? bus.req_addr  : lat_addr;
    assign eff_wdata = accept ? bus.req_wdata : lat_wdata;

    // Unsigned 32-bit check; an address below BASE_ADDR is rejected before
    // the subtraction result is trusted.
    assign offset  = eff_addr - BASE_ADDR;
    assign req_err = (eff_addr < BASE_ADDR) || (offset >= SPAN) ||
                     (eff_addr[1:0] != 2'b00);
    assign idx     = offset[IDX_W+1:2];

    assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                        ((state == ST_WAIT) && (cnt <= 4'd1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign busy           = (state != ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_rdata = (state == ST_RESP) ? rdata_q : 32'd0;
    assign bus.resp_error = (state == ST_RESP) ? error_q : 1'b0;

    always_ff @(negedge clock) begin
        if (clear) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            rdata_q   <= 32'd0;
            error_q   <= 1'b0;
            err_count <= 8'd0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i[IDX_W-1:0]] <= (i == 0) ? 32'd100 :
                                     (i == 1) ? 32'd200 : 32'd0;
            end
        end else begin
            state <= state_nxt;

            if (accept) begin
                lat_write <= bus.req_write;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                cnt       <= WAIT_INIT;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (enter_resp) begin
                error_q <= req_err;
                rdata_q <= (!req_err && !eff_write) ? mem[idx] : 32'd0;
                if (!req_err && eff_write) begin
                    mem[idx] <= eff_wdata;
                end
                if (req_err && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 256;
    localparam int          W0    = 2;
    localparam int          W1    = 0;

    logic       clock = 1'b0;
    logic       clear;
    logic       busy0, busy1;
    logic [7:0] ec0, ec1;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) dut0 (
        .clock(clock), .clear(clear), .bus(bus0), .busy(busy0), .err_count(ec0)
    );

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) dut1 (
        .clock(clock), .clear(clear), .bus(bus1), .busy(busy1), .err_count(ec1)
    );

    always #5 clock = ~clock;

    // Transaction-level reference: one memory image and one pending request per DUT.
    logic [31:0] mmem [2][DEPTH];
    int          idle_from [2];
    int          resp_cyc  [2];
    bit          p_w       [2];
    bit          p_err     [2];
    int          p_idx     [2];
    logic [31:0] p_d       [2];
    int          errs      [2];
    int          cyc;
    int          vectors;
    int          miscompares;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        logic [1:0] lo;
        lo = a[1:0];
        return (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4)) && (lo == 2'b00);
    endfunction

    task automatic model_clear(input int i);
        for (int k = 0; k < DEPTH; k++) mmem[i][k] = 32'd0;
        mmem[i][0]   = 32'd100;
        mmem[i][1]   = 32'd200;
        idle_from[i] = cyc + 1;
        resp_cyc[i]  = -1;
        errs[i]      = 0;
    endtask

    task automatic step(input bit clr, input bit v, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
        logic        g_rdy [2];
        logic        g_bsy [2];
        logic        g_val [2];
        logic [31:0] g_rd  [2];
        logic        g_er  [2];
        logic [7:0]  g_ec  [2];
        logic [31:0] exp_rd;
        bit          exp_v, exp_er, exp_rdy;
        int          wc;
        #1;
        g_rdy[0] = bus0.req_ready;  g_rdy[1] = bus1.req_ready;
        g_bsy[0] = busy0;           g_bsy[1] = busy1;
        g_val[0] = bus0.resp_valid; g_val[1] = bus1.resp_valid;
        g_rd[0]  = bus0.resp_rdata; g_rd[1]  = bus1.resp_rdata;
        g_er[0]  = bus0.resp_error; g_er[1]  = bus1.resp_error;
        g_ec[0]  = ec0;             g_ec[1]  = ec1;
        for (int i = 0; i < 2; i++) begin
            exp_v   = (resp_cyc[i] == cyc);
            exp_rd  = 32'd0;
            exp_er  = 1'b0;
            exp_rdy = (cyc >= idle_from[i]);
            if (exp_v) begin
                exp_er = p_err[i];
                if (!p_err[i] && !p_w[i]) exp_rd = mmem[i][p_idx[i]];
                if (!p_err[i] && p_w[i])  mmem[i][p_idx[i]] = p_d[i];
                if (p_err[i] && errs[i] < 255) errs[i]++;
            end
            chk($sformatf("d%0d_ready", i),  32'(g_rdy[i]), 32'(exp_rdy));
            chk($sformatf("d%0d_busy", i),   32'(g_bsy[i]), 32'(!exp_rdy));
            chk($sformatf("d%0d_rvalid", i), 32'(g_val[i]), 32'(exp_v));
            chk($sformatf("d%0d_rdata", i),  g_rd[i],       exp_rd);
            chk($sformatf("d%0d_rerror", i), 32'(g_er[i]),  32'(exp_er));
            chk($sformatf("d%0d_errcnt", i), 32'(g_ec[i]),  32'(errs[i]));
        end

        clear          = clr;
        bus0.req_valid = v;  bus1.req_valid = v;
        bus0.req_write = w;  bus1.req_write = w;
        bus0.req_addr  = a;  bus1.req_addr  = a;
        bus0.req_wdata = d;  bus1.req_wdata = d;

        for (int i = 0; i < 2; i++) begin
            wc = (i == 0) ? W0 : W1;
            if (clr) begin
                model_clear(i);
            end else if (v && cyc >= idle_from[i]) begin
                resp_cyc[i]  = cyc + 1 + wc;
                idle_from[i] = cyc + 2 + wc;
                p_w[i]       = w;
                p_err[i]     = !addr_ok(a);
                p_idx[i]     = int'((a - BASE) >> 2) & (DEPTH - 1);
                p_d[i]       = d;
            end
        end
        @(posedge clock);
        cyc++;
    endtask

    task automatic req(input bit w, input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, w, a, d);
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0, 1, 2: a = BASE + ($urandom_range(0, DEPTH - 1) << 2);
            3:       a = BASE + ($urandom_range(0, 3) << 2);
            4:       a = BASE + 32'(DEPTH * 4) - 32'd4;
            5:       a = BASE + 32'(DEPTH * 4);
            6:       a = BASE - 32'd4;
            default: a = BASE + ($urandom_range(0, DEPTH - 1) << 2) + 32'($urandom_range(1, 3));
        endcase
        if ($urandom_range(0, 15) == 0) a = $urandom;
        return a;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        clear       = 1'b1;
        bus0.req_valid = 1'b0; bus1.req_valid = 1'b0;
        bus0.req_write = 1'b0; bus1.req_write = 1'b0;
        bus0.req_addr  = 32'd0; bus1.req_addr  = 32'd0;
        bus0.req_wdata = 32'd0; bus1.req_wdata = 32'd0;
        repeat (3) @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            model_clear(i);
            idle_from[i] = 0;
        end

        // load after reset, store/load, error cases
        req(1'b0, 32'h1000_0004, 32'd0);
        req(1'b1, 32'h1000_0008, 32'h0000_0007);
        req(1'b0, 32'h1000_0008, 32'd0);
        req(1'b0, 32'h1000_0400, 32'd0);
        req(1'b1, 32'h0FFF_FFFC, 32'h1234_5678);
        req(1'b0, 32'h1000_0002, 32'd0);
        req(1'b0, 32'h1000_0000, 32'd0);
        req(1'b0, 32'h1000_03FC, 32'd0);

        // back-to-back with req_valid held high
        repeat (12) step(1'b0, 1'b1, 1'b0, 32'h1000_0000, 32'd0);
        repeat (4)  step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // clear while the store is waiting
        step(1'b0, 1'b1, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        req(1'b0, 32'h1000_0000, 32'd0);

        // randomized traffic
        for (int n = 0; n < 700; n++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60,
                 1'($urandom_range(0, 1)), pick_addr(), $urandom);
        end

        // drive err_count into saturation
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (1100) step(1'b0, 1'b1, 1'b0, BASE + 32'(DEPTH * 4), 32'd0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle responder for the processor's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and holds it for a programmable number of wait states. It then returns a one-cycle response carrying read data or an error flag. It replaces the zero-latency data memory so the datapath and a future stall-capable pipeline can be exercised against realistic memory latency.

## Interface
Parameters:
- BASE_ADDR, 32'h10000000, byte address of word 0
- DEPTH_WORDS, 256, number of 32-bit words (1 KB)
- WAIT_CYCLES, 2, wait states between acceptance and response (0..15)

Ports:
- clock  in  1  single clock; all state updates on the falling edge
- clear  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_ready  out  1  responder can accept a request this cycle
- resp_valid  out  1  response valid, exactly one cycle per accepted request
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_error  out  1  request was out of range or misaligned
- busy  out  1  a request is in flight (state != IDLE)
- err_count  out  8  saturating count of error responses

## Operation
- Storage: DEPTH_WORDS x 32. On clear: word0 = 100, word1 = 200, all other words 0.
- Index = (addr - BASE_ADDR) >> 2.
- A request is valid when BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS and addr[1:0] == 0. Otherwise it is an error.
- FSM states IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. When req_valid is high at an edge, latch addr, wdata and write, and set the wait counter to WAIT_CYCLES. Go to WAIT, or straight to RESP if WAIT_CYCLES = 0. When req_valid is low, stay in IDLE.
  - WAIT: req_ready = 0. The counter decrements each edge. At the edge where the counter equals 1, go to RESP. Requests presented in this state are ignored, not queued.
  - RESP: req_valid is ignored; resp_valid = 1. At the next edge, go to IDLE.
- Store commit: the memory write happens on the edge that enters RESP, and only for a non-error store.
- Load data: resp_rdata is registered on the edge that enters RESP, from memory contents before any write on that edge.
- Error response: resp_error = 1 and resp_rdata = 0. Memory is unchanged. err_count increments, saturating at 255.
- Outputs outside RESP: resp_rdata and resp_error are driven to 0.
- Input stability: request inputs are only sampled at acceptance; changes afterwards have no effect.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_error 0, busy 0, err_count 0, wait counter 0, memory at its initial contents.
- Latency: for a request accepted at edge E, resp_valid is high for the single cycle after edge E + WAIT_CYCLES.
- Throughput: one request per WAIT_CYCLES + 2 cycles. There is no acceptance in the RESP cycle.
- Response side: no back-pressure. The response is lost if the requester ignores it.
- clear mid-operation: clear wins over all other activity.
  - The in-flight request is dropped and the pending store is not committed.
  - Memory and counters are reinitialised.
  - req_ready is 1 in the cycle after the clear edge.
- Boundary addresses:
  - BASE_ADDR + 4*DEPTH_WORDS - 4 is valid.
  - BASE_ADDR + 4*DEPTH_WORDS is an error.
  - BASE_ADDR - 4 is an error.
- Unsigned comparison only; address arithmetic is 32-bit and has no wrap-around exception.
- busy equals the inverse of req_ready.

## Test plan
- Load after reset, WAIT_CYCLES = 2: load 0x10000004 accepted at edge E → resp_valid only in the cycle after E+2, with resp_rdata = 200 (0xC8) and resp_error 0.
- Store then load: store 0x00000007 to 0x10000008, then load 0x10000008 → second response has rdata 7. Store response has rdata 0.
- Errors: load 0x10000400, store 0x0FFFFFFC and load 0x10000002 → three responses with resp_error 1 and rdata 0. err_count = 3. Words 0..255 unchanged.
- Back-to-back requests: req_valid held high with two loads → second accepted exactly WAIT_CYCLES + 2 cycles after the first. Requests during WAIT/RESP are not accepted. req_ready is low in those cycles.
- Zero-wait configuration, WAIT_CYCLES = 0: load 0x10000000 → resp_valid in the cycle after acceptance with rdata 100 (0x64). A request is accepted every 2 cycles.
- clear mid-request: store 0xDEADBEEF to 0x10000000, assert clear in WAIT → no resp_valid. A subsequent load of 0x10000000 returns 100. err_count = 0.
